// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit bundle between byte requesters, the arbiter and the UART TX core.
// master = requesters + transmitter side, slave = arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid_i;
    logic [8*N_REQ-1:0] req_data_i;
    logic [N_REQ-1:0]   req_last_i;
    logic [N_REQ-1:0]   req_crc_en_i;
    logic [N_REQ-1:0]   req_ready_o;
    logic [N_REQ-1:0]   grant_o;
    logic [7:0]         data_o;
    logic               crc_en_o;
    logic               tx_start_cmd_o;
    logic               tx_int_i;
    logic               busy_o;
    logic               timeout_o;

    modport master (
        output req_valid_i, req_data_i, req_last_i, req_crc_en_i, tx_int_i,
        input  req_ready_o, grant_o, data_o, crc_en_o, tx_start_cmd_o, busy_o, timeout_o
    );

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, req_crc_en_i, tx_int_i,
        output req_ready_o, grant_o, data_o, crc_en_o, tx_start_cmd_o, busy_o, timeout_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters,
// with frame locking and a completion watchdog.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_W   = 16,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input logic              clk_i,
    input logic              rst_i,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TIMEOUT_W-1:0] WD_TERM = TIMEOUT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StHold} state_e;

    state_e             state_q;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      owner_q;
    logic               lock_q;
    logic [TIMEOUT_W-1:0] wdog_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   ready_q;
    logic [7:0]         data_q;
    logic               crc_en_q;
    logic               start_q;
    logic               busy_q;
    logic               timeout_q;

    logic               win_found;
    logic [PW-1:0]      win_idx;
    logic [PW-1:0]      cand_idx;
    logic               launch;
    logic [PW-1:0]      launch_idx;
    logic [7:0]         launch_data;
    logic               wd_expired;

    // First valid requester after the pointer, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand_idx = PW'((32'(ptr_q) + i) % N_REQ);
            if (!win_found && bus.req_valid_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        launch_idx  = (state_q == StHold) ? owner_q : win_idx;
        launch      = ((state_q == StIdle) && win_found) ||
                      ((state_q == StHold) && bus.req_valid_i[owner_q]);
        launch_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (launch_idx == PW'(k)) launch_data = bus.req_data_i[8*k +: 8];
        end
        wd_expired  = (wdog_q >= WD_TERM);
    end

    // A completion with the frame still locked always passes through HOLD, which
    // gives the one idle cycle between tx_int and the next start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            ptr_q     <= PW'(N_REQ - 1);
            owner_q   <= '0;
            lock_q    <= 1'b0;
            wdog_q    <= '0;
            grant_q   <= '0;
            ready_q   <= '0;
            data_q    <= '0;
            crc_en_q  <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            start_q   <= 1'b0;
            ready_q   <= '0;
            timeout_q <= 1'b0;
            if (launch) begin
                state_q  <= StStart;
                owner_q  <= launch_idx;
                ptr_q    <= launch_idx;
                grant_q  <= N_REQ'(1) << launch_idx;
                ready_q  <= N_REQ'(1) << launch_idx;
                data_q   <= launch_data;
                crc_en_q <= bus.req_crc_en_i[launch_idx];
                lock_q   <= !bus.req_last_i[launch_idx];
                start_q  <= 1'b1;
                wdog_q   <= '0;
                busy_q   <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: busy_q <= 1'b0;
                    StStart: begin
                        state_q <= StWait;
                        wdog_q  <= wdog_q + 1'b1;
                    end
                    StWait: begin
                        if (bus.tx_int_i) begin
                            wdog_q <= wdog_q + 1'b1;
                            if (lock_q) begin
                                state_q <= StHold;
                            end else begin
                                state_q <= StIdle;
                                grant_q <= '0;
                                busy_q  <= 1'b0;
                            end
                        end else if (wd_expired) begin
                            state_q   <= StIdle;
                            lock_q    <= 1'b0;
                            grant_q   <= '0;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end else begin
                            wdog_q <= wdog_q + 1'b1;
                        end
                    end
                    StHold: begin
                        if (wd_expired) begin
                            state_q   <= StIdle;
                            lock_q    <= 1'b0;
                            grant_q   <= '0;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end else begin
                            wdog_q <= wdog_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.req_ready_o    = ready_q;
    assign bus.grant_o        = grant_q;
    assign bus.data_o         = data_q;
    assign bus.crc_en_o       = crc_en_q;
    assign bus.tx_start_cmd_o = start_q;
    assign bus.busy_o         = busy_q;
    assign bus.timeout_o      = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: dut_a uses the default watchdog, dut_b a 16-cycle watchdog.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   extra;

    uart_tx_arbiter_if #(.N_REQ(4)) ia ();
    uart_tx_arbiter_if #(.N_REQ(4)) ib ();

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_W(16), .TIMEOUT_CYC(50000)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ia)
    );

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_W(16), .TIMEOUT_CYC(16)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ib)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One completion pulse on dut_a, sampled by the next edge.
    task automatic int_a();
        ia.tx_int_i = 1'b1;
        tick();
        ia.tx_int_i = 1'b0;
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        ia.req_valid_i = '0; ia.req_data_i = '0; ia.req_last_i = '0;
        ia.req_crc_en_i = '0; ia.tx_int_i = 1'b0;
        ib.req_valid_i = '0; ib.req_data_i = '0; ib.req_last_i = '0;
        ib.req_crc_en_i = '0; ib.tx_int_i = 1'b0;
        tick();
        tick();
        chk("rst_grant", 32'(ia.grant_o), 0);
        chk("rst_busy", 32'(ia.busy_o), 0);
        chk("rst_start", 32'(ia.tx_start_cmd_o), 0);
        chk("rst_ready", 32'(ia.req_ready_o), 0);
        rst = 1'b0;

        // 1: two requesters, requester 1 first after reset
        ia.req_valid_i = 4'b1010;
        ia.req_data_i = {8'hA3, 8'h00, 8'hA1, 8'h00};
        ia.req_last_i = 4'b1111;
        ia.req_crc_en_i = 4'b0010;
        tick();
        chk("t1_start", 32'(ia.tx_start_cmd_o), 1);
        chk("t1_data", 32'(ia.data_o), 32'hA1);
        chk("t1_grant", 32'(ia.grant_o), 32'b0010);
        chk("t1_ready", 32'(ia.req_ready_o), 32'b0010);
        chk("t1_crc", 32'(ia.crc_en_o), 1);
        ia.req_valid_i = 4'b1000;
        tick();
        chk("t1_start_off", 32'(ia.tx_start_cmd_o), 0);
        int_a();
        chk("t1_gap_busy", 32'(ia.busy_o), 0);
        tick();
        chk("t1_start2", 32'(ia.tx_start_cmd_o), 1);
        chk("t1_data2", 32'(ia.data_o), 32'hA3);
        chk("t1_grant2", 32'(ia.grant_o), 32'b1000);
        chk("t1_crc2", 32'(ia.crc_en_o), 0);
        ia.req_valid_i = 4'b0000;
        tick();
        int_a();
        chk("t1_idle_busy", 32'(ia.busy_o), 0);
        chk("t1_idle_grant", 32'(ia.grant_o), 0);

        // 2: all valid, round-robin 0,1,2,3,0 with completion 10 cycles after start
        ia.req_valid_i = 4'b1111;
        ia.req_data_i = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        extra = 0;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("t2_grant", 32'(ia.grant_o), 32'(1) << order[g]);
            chk("t2_ready", 32'(ia.req_ready_o), 32'(1) << order[g]);
            chk("t2_data", 32'(ia.data_o), 32'hB0 + 32'(order[g]));
            for (int c = 0; c < 9; c++) begin
                tick();
                if (ia.tx_start_cmd_o !== 1'b0 || ia.req_ready_o !== 4'b0000) extra++;
            end
            int_a();
            chk("t2_idle", 32'(ia.busy_o), 0);
        end
        chk("t2_extra_pulses", 32'(extra), 0);

        // 3: requester 2 three-byte frame stays contiguous ahead of requester 0
        ia.req_valid_i = 4'b0101;
        ia.req_data_i = {8'h00, 8'h11, 8'h00, 8'h0A};
        ia.req_last_i = 4'b1011;
        tick();
        chk("t3_grant1", 32'(ia.grant_o), 32'b0100);
        chk("t3_data1", 32'(ia.data_o), 32'h11);
        ia.req_data_i[23:16] = 8'h22;
        tick();
        int_a();
        chk("t3_gap_start", 32'(ia.tx_start_cmd_o), 0);
        chk("t3_gap_grant", 32'(ia.grant_o), 32'b0100);
        tick();
        chk("t3_start2", 32'(ia.tx_start_cmd_o), 1);
        chk("t3_data2", 32'(ia.data_o), 32'h22);
        chk("t3_ready2", 32'(ia.req_ready_o), 32'b0100);
        ia.req_data_i[23:16] = 8'h33;
        ia.req_last_i = 4'b1111;
        tick();
        int_a();
        tick();
        chk("t3_start3", 32'(ia.tx_start_cmd_o), 1);
        chk("t3_data3", 32'(ia.data_o), 32'h33);
        ia.req_valid_i = 4'b0001;
        tick();
        int_a();
        chk("t3_unlock_grant", 32'(ia.grant_o), 0);
        tick();
        chk("t3_k0_grant", 32'(ia.grant_o), 32'b0001);
        chk("t3_k0_data", 32'(ia.data_o), 32'h0A);
        ia.req_valid_i = 4'b0000;
        tick();
        int_a();

        // 4: requester 1 locks, drops valid, HOLD blocks requester 0 for 20 cycles
        ia.req_valid_i = 4'b0011;
        ia.req_data_i = {8'h00, 8'h00, 8'h55, 8'h0B};
        ia.req_last_i = 4'b1101;
        tick();
        chk("t4_grant", 32'(ia.grant_o), 32'b0010);
        chk("t4_data", 32'(ia.data_o), 32'h55);
        ia.req_valid_i = 4'b0001;
        tick();
        int_a();
        extra = 0;
        for (int c = 0; c < 19; c++) begin
            if (ia.tx_start_cmd_o !== 1'b0 || ia.grant_o !== 4'b0010 || ia.busy_o !== 1'b1)
                extra++;
            tick();
        end
        chk("t4_hold_stable", 32'(extra), 0);
        chk("t4_hold_grant", 32'(ia.grant_o), 32'b0010);
        ia.req_valid_i = 4'b0011;
        ia.req_data_i[15:8] = 8'h66;
        ia.req_last_i = 4'b1111;
        tick();
        chk("t4_resume_start", 32'(ia.tx_start_cmd_o), 1);
        chk("t4_resume_data", 32'(ia.data_o), 32'h66);
        chk("t4_resume_ready", 32'(ia.req_ready_o), 32'b0010);
        ia.req_valid_i = 4'b0001;
        tick();
        int_a();
        tick();
        chk("t4_k0_data", 32'(ia.data_o), 32'h0B);
        ia.req_valid_i = 4'b0000;
        tick();
        int_a();

        // 5: watchdog on dut_b (16 cycles)
        ib.req_valid_i = 4'b0001;
        ib.req_data_i = {8'h00, 8'h88, 8'h00, 8'h77};
        ib.req_last_i = 4'b1111;
        tick();
        chk("t5_start", 32'(ib.tx_start_cmd_o), 1);
        chk("t5_grant", 32'(ib.grant_o), 32'b0001);
        ib.req_valid_i = 4'b0100;
        extra = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (ib.timeout_o !== 1'b0) extra++;
        end
        chk("t5_no_early_to", 32'(extra), 0);
        tick();
        chk("t5_timeout", 32'(ib.timeout_o), 1);
        chk("t5_to_grant", 32'(ib.grant_o), 0);
        chk("t5_to_busy", 32'(ib.busy_o), 0);
        tick();
        chk("t5_rearb_start", 32'(ib.tx_start_cmd_o), 1);
        chk("t5_rearb_grant", 32'(ib.grant_o), 32'b0100);
        chk("t5_rearb_data", 32'(ib.data_o), 32'h88);
        chk("t5_to_pulse", 32'(ib.timeout_o), 0);
        ib.req_valid_i = 4'b0000;
        for (int c = 1; c <= 15; c++) tick();
        ib.tx_int_i = 1'b1;
        tick();
        ib.tx_int_i = 1'b0;
        chk("t5_race_no_to", 32'(ib.timeout_o), 0);
        chk("t5_race_busy", 32'(ib.busy_o), 0);
        tick();
        chk("t5_race_no_to2", 32'(ib.timeout_o), 0);

        // 6: asynchronous reset in WAIT mid-frame
        ia.req_valid_i = 4'b1001;
        ia.req_data_i = {8'h99, 8'h00, 8'h00, 8'h0C};
        ia.req_last_i = 4'b0111;
        tick();
        chk("t6_grant", 32'(ia.grant_o), 32'b1000);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_grant", 32'(ia.grant_o), 0);
        chk("t6_rst_busy", 32'(ia.busy_o), 0);
        chk("t6_rst_data", 32'(ia.data_o), 0);
        chk("t6_rst_to", 32'(ia.timeout_o), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_first_grant", 32'(ia.grant_o), 32'b0001);
        chk("t6_first_data", 32'(ia.data_o), 32'h0C);
        ia.req_valid_i = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among N_REQ byte requesters using round-robin arbitration.
- Frame locking keeps a multi-byte frame from one requester contiguous on the line.
- Sequences the transmitter: presents the byte and CRC enable, pulses the start command, then waits for the transmitter's completion interrupt before issuing the next byte.
- Sits between the software/DMA-facing request sources and the UART TX core; a watchdog recovers from a transmitter that never completes.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_W, 16, width of the watchdog counter.
- TIMEOUT_CYC, 50000, cycles allowed in WAIT/HOLD before abort (must be < 2^TIMEOUT_W).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset.
- req_valid_i  in  N_REQ  per-requester byte valid.
- req_data_i  in  8*N_REQ  byte of requester k on bits [8k+7:8k].
- req_last_i  in  N_REQ  byte is last of its frame.
- req_crc_en_i  in  N_REQ  CRC enable for that byte.
- req_ready_o  out  N_REQ  one-cycle accept pulse; the byte has been consumed.
- grant_o  out  N_REQ  one-hot current owner; zero when idle.
- data_o  out  8  byte to the transmitter.
- crc_en_o  out  1  CRC enable to the transmitter.
- tx_start_cmd_o  out  1  one-cycle start command to the transmitter.
- tx_int_i  in  1  transmitter completion pulse (end of stop bit).
- busy_o  out  1  high whenever state is not IDLE.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Clock/reset: one clock, clk_i; reset is asynchronous and active-high (rst_i).
- Reset values and outputs:
  - All outputs are registered and reset to 0.
  - State resets to IDLE, lock to 0, and the round-robin pointer to N_REQ-1, so requester 0 has first priority.
  - Reset mid-transfer aborts silently: no ready pulse and no timeout pulse.
- Requester handshake:
  - Once asserted, req_valid_i[k] and its data/last/crc_en must stay stable until req_ready_o[k].
  - The arbiter never pulses ready for a requester whose valid is low.
- States: IDLE, START, WAIT, HOLD.
- IDLE:
  - If any valid is high, the winner is the first valid index searching from pointer+1 upward with wrap-around.
  - Next cycle: state START; grant_o = onehot(winner); data_o and crc_en_o latched from the winner; pointer = winner.
- START (exactly 1 cycle):
  - tx_start_cmd_o = 1 and req_ready_o[owner] = 1.
  - lock = !req_last_i[owner] as sampled for this byte.
  - Watchdog cleared; next state WAIT.
  - Latency: valid seen in IDLE at cycle t gives START outputs at t+1.
- WAIT:
  - Watchdog increments each cycle.
  - On tx_int_i:
    - If lock=1 and req_valid_i[owner]=1: go to START next cycle with the new owner byte latched (back-to-back, 1 idle cycle between tx_int and start).
    - If lock=1 and owner not valid: go to HOLD.
    - Otherwise: go to IDLE and clear grant_o.
  - tx_int_i outside WAIT is ignored.
- HOLD:
  - Lock is kept, grant_o stays on the owner, and other requesters are blocked.
  - Watchdog keeps counting (it was cleared at START).
  - When the owner becomes valid: go to START with that byte.
- Watchdog:
  - In WAIT or HOLD, when the count reaches TIMEOUT_CYC-1 with no tx_int_i/owner valid that cycle: timeout_o pulses 1 cycle, lock clears, grant_o clears, state goes to IDLE.
  - The pending owner byte is not accepted.
  - If tx_int_i (WAIT) or owner valid (HOLD) coincides with the terminal count, the event wins and no timeout is raised.
- Fairness:
  - The pointer updates only at grant, so an unlocked requester gets at most one byte before others are considered.
  - A locked frame is unbounded except by the watchdog.
- Invariants:
  - grant_o is one-hot or zero.
  - tx_start_cmd_o is never high in consecutive cycles.
  - At most one req_ready_o bit is high.
  - data_o and crc_en_o are stable from START until the next START.

Test Plan:
1. After reset, req_valid_i=4'b1010 with bytes 0xA1 (k1), 0xA3 (k3), last=1 → start pulse with data_o=0xA1, grant_o=4'b0010; after tx_int_i, start with data_o=0xA3, grant_o=4'b1000; after the second tx_int_i, busy_o=0.
2. All four requesters valid and last=1, tx_int_i returned 10 cycles after each start → grant order 0,1,2,3,0; exactly one ready pulse per start.
3. Requester 2 sends a 3-byte frame 0x11, 0x22, 0x33 (last on 0x33) while requester 0 is valid → all three bytes go out before requester 0; tx_start_cmd_o is asserted 2 cycles after each tx_int_i (next state START, output 1 cycle later).
4. Frame lock: requester 1 drops valid after a non-last byte, 0 stays valid → HOLD with grant_o=4'b0010 and no start; requester 1 reasserts after 20 cycles → start with its byte.
5. TIMEOUT_CYC=16 and tx_int_i never arrives → timeout_o pulses at cycle 16 after START, grant_o=0, state IDLE; a pending valid re-arbitrates next cycle. Repeat with tx_int_i on the terminal cycle → no timeout.
6. rst_i asserted in WAIT mid-frame → all outputs 0 immediately (asynchronously); after release, requester 0 wins first.
